t05_header_synth: RTL and testbench
===================================

# t05_header_synth

Serializes Huffman header entries for the SPI writer, one entry per character the codebook traversal finds. Each `char_found` pulse latches the character index and its path, then streams them bit-serially over a valid/ready handshake. Each entry is the index, the path length and the path bits. After the last bit of an entry is accepted, the block pulses `write_finish` back to the codebook stage so tree traversal resumes.

## Interface
- `FIN_CODE`, default 4'b0101: codebook `finished` value meaning traversal done.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `char_found`  in  1: one-cycle pulse, entry available.
- `char_index`  in  8: character index, valid with `char_found`.
- `char_path`  in  128: path, valid with `char_found`. Highest set bit is the control bit; the bits below it are the path, MSB = first move, 0 = left, 1 = right.
- `cb_finished`  in  4: codebook finish code.
- `bit_ready`  in  1: SPI writer accepts a bit.
- `bit_out`  out  1: serial header bit.
- `bit_valid`  out  1: `bit_out` is valid.
- `write_finish`  out  1: one-cycle pulse, entry fully accepted.
- `header_done`  out  1: level, header complete.
- `overrun`  out  1: sticky flag, `char_found` arrived while busy.

## Operation
- States: IDLE, PREFIX (macro only), CHAR, LEN, PATH, ACK, TERM (macro only), FIN.
- **IDLE**, on `char_found`:
  - Latch `char_index` into `idx_q`.
  - Latch `char_path` into `path_q`.
  - Latch L = bit position of the highest set bit of `char_path` into `len_q`. L ranges 0..127.
  - If `char_path` is 0, L = 0.
  - Go to CHAR, or to PREFIX with the macro.
- **IDLE**, on `cb_finished == FIN_CODE` with no `char_found`: go to TERM with the macro, else FIN. `char_found` has priority when both occur in the same cycle.
- **CHAR**: emit `idx_q[7:0]`, MSB first, 8 bits.
- **LEN**: emit `len_q[6:0]`, MSB first, 7 bits.
- **PATH**: emit `path_q[L-1]` down to `path_q[0]`, L bits. If L = 0, skip straight from LEN to ACK.
- **ACK**: `write_finish` = 1 for exactly one cycle, then IDLE.
- **FIN**: `header_done` = 1 and stays set until reset. All inputs are ignored.
- Bit counter: 7 bits, loaded at each field start, decremented on every handshake. A field ends on the handshake where the counter reaches 0.
- Handshake:
  - A bit transfers when `bit_valid && bit_ready`.
  - `bit_out` and `bit_valid` are registered and held stable while `bit_valid && !bit_ready`.
  - `bit_valid` never drops without a transfer, except on reset.
- `char_found` in any non-IDLE state is ignored and sets `overrun`, which clears only on reset.
- Entry length: 15 + L bits, or 16 + L bits with the macro.

## Timing
- Reset values: `bit_out`=0, `bit_valid`=0, `write_finish`=0, `header_done`=0, `overrun`=0, state IDLE.
- `char_found` at cycle N → first bit valid at N+1, provided `bit_ready` is held high.
- With `bit_ready` held high: one bit per cycle with no bubbles between fields.
- Last handshake at cycle M → `write_finish` high at M+1 → back in IDLE at M+2, able to accept a new `char_found`.
- `rst` asserted mid-stream: all outputs return to reset values immediately and any partial entry is discarded.

## Configuration
- `T05_HEADER_FRAMING_EN`:
  - Defined: each entry is preceded by a prefix bit 1 (PREFIX state). On finish, one terminator bit 0 is emitted (TERM state); FIN is entered after its handshake. `write_finish` does not pulse for the terminator.
  - Undefined: no prefix or terminator bits; finish goes directly from IDLE to FIN on the next cycle.

## Structure
- Package `t05_header_pkg`:
  - State enum `state_hs`.
  - `FIN_CODE` default.
  - Field widths `CHAR_W`=8, `LEN_W`=7, `PATH_W`=128.
- Sub-module `t05_msb_find`: combinational 128-bit priority encoder producing a 7-bit position plus an any-set flag. Used only for latching L.

## Test plan
- `char_index`=0x41, `char_path`=128'b1011, `bit_ready`=1 → bits 01000001 0000011 011 (18 bits) on consecutive cycles; `write_finish` pulses one cycle after the 18th bit.
- Same stimulus with `bit_ready` toggled 1,0,0,1,… → identical bit sequence; `bit_out` stable during stalls; exactly one `write_finish`.
- `char_path`=128'b1 (L=0), `char_index`=0x00 → 15 zero bits, then `write_finish`.
- `char_path` with bit 127 set and lower bits alternating 1010… → length field 1111111, then 127 path bits starting with 1; total 142 bits.
- `char_found` during CHAR → `overrun`=1 and the current entry completes unchanged. `cb_finished`=4'b0101 in IDLE → `header_done`=1; with the macro, a single 0 bit is emitted first.
- `rst` pulsed after the 5th bit of an entry → all outputs 0; a new entry after reset streams correctly from bit 0.

Source files
------------

// File: rtl/t05_header_pkg.sv
// ---------------------------------------------------------------------------
// t05_header_pkg
// Shared types and constants for the Huffman header serializer.
//   state_hs          : serializer FSM states (PREFIX/TERM are only reached
//                       when T05_HEADER_FRAMING_EN is defined)
//   FIN_CODE_DEFAULT  : codebook 'finished' code meaning traversal is done
//   CHAR_W/LEN_W/PATH_W : header field widths
// ---------------------------------------------------------------------------
package t05_header_pkg;

    localparam int CHAR_W = 8;
    localparam int LEN_W  = 7;
    localparam int PATH_W = 128;

    localparam logic [3:0] FIN_CODE_DEFAULT = 4'b0101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREFIX = 3'd1,
        ST_CHAR   = 3'd2,
        ST_LEN    = 3'd3,
        ST_PATH   = 3'd4,
        ST_ACK    = 3'd5,
        ST_TERM   = 3'd6,
        ST_FIN    = 3'd7
    } state_hs;

endpackage : t05_header_pkg

// File: rtl/t05_msb_find.sv
// ---------------------------------------------------------------------------
// t05_msb_find
// Combinational priority encoder: position of the highest set bit of a
// PATH_W-bit vector.
//   vec : input vector
//   pos : index of the highest set bit (0 when vec is all zero)
//   any : 1 when at least one bit of vec is set
// ---------------------------------------------------------------------------
module t05_msb_find
    import t05_header_pkg::*;
(
    input  logic [PATH_W-1:0] vec,
    output logic [LEN_W-1:0]  pos,
    output logic              any
);

    always_comb begin
        // NOTE: defaults first so every path assigns pos/any; otherwise a latch is inferred.
        pos = '0;
        any = 1'b0;
        // Ascending scan: the last hit wins, which is the highest set bit.
        for (int i = 0; i < PATH_W; i++) begin
            if (vec[i]) begin
                pos = LEN_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule : t05_msb_find

// File: rtl/t05_header_synth.sv
// ---------------------------------------------------------------------------
// t05_header_synth
// Serializes one Huffman header entry (char index, path length, path bits)
// per char_found pulse over a bit_valid/bit_ready handshake, then pulses
// write_finish so the codebook traversal can resume.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   char_found      : one-cycle pulse, entry available
//   char_index[7:0] : character index, valid with char_found
//   char_path[127:0]: path with a leading control bit (highest set bit)
//   cb_finished[3:0]: codebook finish code; FIN_CODE means traversal done
//   bit_ready       : downstream accepts a bit
//   bit_out         : serial header bit (registered)
//   bit_valid       : bit_out valid (registered)
//   write_finish    : one-cycle pulse after the last bit of an entry
//   header_done     : level, header complete (until reset)
//   overrun         : sticky, char_found seen while busy
//
// Configuration macro: T05_HEADER_FRAMING_EN
//   defined   -> prefix bit 1 before each entry, terminator bit 0 at finish
//   undefined -> no framing bits; finish goes straight to FIN
// ---------------------------------------------------------------------------
module t05_header_synth
    import t05_header_pkg::*;
#(
    parameter logic [3:0] FIN_CODE = FIN_CODE_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              char_found,
    input  logic [CHAR_W-1:0] char_index,
    input  logic [PATH_W-1:0] char_path,
    input  logic [3:0]        cb_finished,
    input  logic              bit_ready,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              write_finish,
    output logic              header_done,
    output logic              overrun
);

    state_hs           state;
    logic [CHAR_W-1:0] idx_q;
    logic [PATH_W-1:0] path_q;
    logic [LEN_W-1:0]  len_q;
    // Index of the bit currently on bit_out within its field; a field ends
    // on the handshake that occurs while this is 0.
    logic [LEN_W-1:0]  cnt;

    logic [LEN_W-1:0]  msb_pos;
    logic              msb_any;
    logic [LEN_W-1:0]  cnt_m1;
    logic [LEN_W-1:0]  len_m1;
    logic              xfer;

    t05_msb_find u_msb_find (
        .vec (char_path),
        .pos (msb_pos),
        .any (msb_any)
    );

    assign xfer   = bit_valid && bit_ready;
    assign cnt_m1 = cnt - 7'd1;
    assign len_m1 = len_q - 7'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Datapath registers are reset too so a discarded partial entry
            // leaves no stale contents behind.
            state        <= ST_IDLE;
            cnt          <= '0;
            idx_q        <= '0;
            path_q       <= '0;
            len_q        <= '0;
            bit_out      <= 1'b0;
            bit_valid    <= 1'b0;
            write_finish <= 1'b0;
            header_done  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            if (char_found && state != ST_IDLE && state != ST_FIN)
                overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (char_found) begin
                        idx_q     <= char_index;
                        path_q    <= char_path;
                        len_q     <= msb_any ? msb_pos : '0;
                        bit_valid <= 1'b1;
`ifdef T05_HEADER_FRAMING_EN
                        state     <= ST_PREFIX;
                        cnt       <= '0;
                        bit_out   <= 1'b1;
`else
                        state     <= ST_CHAR;
                        cnt       <= 7'(CHAR_W - 1);
                        bit_out   <= char_index[CHAR_W-1];
`endif
                    end else if (cb_finished == FIN_CODE) begin
`ifdef T05_HEADER_FRAMING_EN
                        state       <= ST_TERM;
                        bit_out     <= 1'b0;
                        bit_valid   <= 1'b1;
`else
                        state       <= ST_FIN;
                        header_done <= 1'b1;
`endif
                    end
                end

`ifdef T05_HEADER_FRAMING_EN
                ST_PREFIX: begin
                    if (xfer) begin
                        state   <= ST_CHAR;
                        cnt     <= 7'(CHAR_W - 1);
                        bit_out <= idx_q[CHAR_W-1];
                    end
                end
`endif

                ST_CHAR: begin
                    if (xfer) begin
                        if (cnt == '0) begin
                            state   <= ST_LEN;
                            cnt     <= 7'(LEN_W - 1);
                            bit_out <= len_q[LEN_W-1];
                        end else begin
                            cnt     <= cnt_m1;
                            bit_out <= idx_q[cnt_m1[2:0]];
                        end
                    end
                end

                ST_LEN: begin
                    if (xfer) begin
                        if (cnt != '0) begin
                            cnt     <= cnt_m1;
                            bit_out <= len_q[cnt_m1[2:0]];
                        end else if (len_q == '0) begin
                            // Empty path: no PATH field at all.
                            state        <= ST_ACK;
                            bit_out      <= 1'b0;
                            bit_valid    <= 1'b0;
                            write_finish <= 1'b1;
                        end else begin
                            state   <= ST_PATH;
                            cnt     <= len_m1;
                            bit_out <= path_q[len_m1];
                        end
                    end
                end

                ST_PATH: begin
                    if (xfer) begin
                        if (cnt == '0) begin
                            state        <= ST_ACK;
                            bit_out      <= 1'b0;
                            bit_valid    <= 1'b0;
                            write_finish <= 1'b1;
                        end else begin
                            cnt     <= cnt_m1;
                            bit_out <= path_q[cnt_m1];
                        end
                    end
                end

                ST_ACK: begin
                    write_finish <= 1'b0;
                    state        <= ST_IDLE;
                end

`ifdef T05_HEADER_FRAMING_EN
                ST_TERM: begin
                    if (xfer) begin
                        state       <= ST_FIN;
                        bit_valid   <= 1'b0;
                        header_done <= 1'b1;
                    end
                end
`endif

                ST_FIN: begin
                    // Terminal: everything is ignored until reset.
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : t05_header_synth

// File: tb/tb_t05_header_synth.sv
// ---------------------------------------------------------------------------
// tb_t05_header_synth
// Scoreboard bench: the stimulus side pushes the expected token stream of
// each entry (bits 0/1, token 2 = write_finish) into exp_q; a monitor on the
// falling edge pops and compares on every handshake and write_finish pulse.
// ---------------------------------------------------------------------------
module tb_t05_header_synth;

    localparam logic [3:0] FIN = 4'b0101;
    localparam int WF_TOKEN = 2;

    logic         clk;
    logic         rst;
    logic         char_found;
    logic [7:0]   char_index;
    logic [127:0] char_path;
    logic [3:0]   cb_finished;
    logic         bit_ready;
    logic         bit_out;
    logic         bit_valid;
    logic         write_finish;
    logic         header_done;
    logic         overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_q[$];
    int n_xfer = 0;
    int n_wf = 0;
    int exp_wf_cyc = -1;
    int last_wf_cyc = -1;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: pattern 1,0,0
    int pat = 0;
    logic stall_prev = 1'b0;
    logic prev_out = 1'b0;

    t05_header_synth dut (
        .clk          (clk),
        .rst          (rst),
        .char_found   (char_found),
        .char_index   (char_index),
        .char_path    (char_path),
        .cb_finished  (cb_finished),
        .bit_ready    (bit_ready),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .write_finish (write_finish),
        .header_done  (header_done),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Downstream ready generator.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bit_ready = 1'b1;
            1:       bit_ready = ($urandom_range(0, 3) != 0);
            default: begin
                bit_ready = (pat % 3 == 0);
                pat++;
            end
        endcase
    end

    // Monitor: compares every transferred bit and every write_finish pulse.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", int'({bit_valid, bit_out}), int'({1'b1, prev_out}));
            stall_prev = bit_valid && !bit_ready;
            prev_out   = bit_out;

            if (bit_valid && bit_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 1, 0);
                end else begin
                    check("bit", int'(bit_out), exp_q.pop_front());
                    if (exp_q.size() > 0 && exp_q[0] == WF_TOKEN)
                        exp_wf_cyc = cyc + 1;
                end
            end

            if (write_finish) begin
                n_wf++;
                last_wf_cyc = cyc;
                if (exp_q.size() == 0)
                    check("unexpected_write_finish", 1, 0);
                else
                    check("write_finish_order", exp_q.pop_front(), WF_TOKEN);
                check("write_finish_latency", cyc, exp_wf_cyc);
            end
        end
    end

    // Reference model: expected header entry built from the entry rules.
    task automatic push_entry(input logic [7:0] idx, input logic [127:0] path, output int nb);
        int l;
        l  = 0;
        nb = 0;
        for (int i = 127; i >= 0; i--) begin
            if (path[i]) begin
                l = i;
                break;
            end
        end
`ifdef T05_HEADER_FRAMING_EN
        exp_q.push_back(1);
        nb++;
`endif
        for (int i = 7; i >= 0; i--) exp_q.push_back(int'(idx[i]));
        for (int i = 6; i >= 0; i--) exp_q.push_back((l >> i) & 1);
        for (int i = l - 1; i >= 0; i--) exp_q.push_back(int'(path[i]));
        nb += 15 + l;
        exp_q.push_back(WF_TOKEN);
    endtask

    task automatic wait_wf(input int wf_before, output logic ok);
        int k;
        k  = 0;
        ok = 1'b0;
        while (k < 3000) begin
            @(posedge clk);
            if (n_wf != wf_before) begin
                ok = 1'b1;
                break;
            end
            k++;
        end
        if (!ok) check("write_finish_timeout", 0, 1);
    endtask

    task automatic send_entry(input logic [7:0] idx, input logic [127:0] path, input bit pulse_overrun);
        int nb;
        int start;
        int wf_before;
        logic ok;
        push_entry(idx, path, nb);
        wf_before = n_wf;
        @(posedge clk); #1;
        char_found = 1'b1;
        char_index = idx;
        char_path  = path;
        start      = cyc;
        @(posedge clk); #1;
        char_found = 1'b0;
        char_index = 8'($urandom);
        char_path  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        check("first_bit_valid", int'(bit_valid), 1);
        if (pulse_overrun) begin
            @(posedge clk); #1;
            char_found = 1'b1;
            @(posedge clk); #1;
            char_found = 1'b0;
            @(negedge clk);
            check("overrun_set", int'(overrun), 1);
        end
        wait_wf(wf_before, ok);
        if (ok && ready_mode == 0)
            check("entry_cycles", last_wf_cyc - start, nb + 1);
    endtask

    initial begin
        logic [127:0] p;
        logic ok;
        int x0;

        rst         = 1'b1;
        char_found  = 1'b0;
        char_index  = '0;
        char_path   = '0;
        cb_finished = 4'd0;
        bit_ready   = 1'b1;
        #2;
        check("reset_bit_out", int'(bit_out), 0);
        check("reset_bit_valid", int'(bit_valid), 0);
        check("reset_write_finish", int'(write_finish), 0);
        check("reset_header_done", int'(header_done), 0);
        check("reset_overrun", int'(overrun), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed entries.
        ready_mode = 0;
        send_entry(8'h41, 128'b1011, 1'b0);
        ready_mode = 2;
        send_entry(8'h41, 128'b1011, 1'b0);
        ready_mode = 0;
        send_entry(8'h00, 128'b1, 1'b0);
        p = '0;
        p[127] = 1'b1;
        for (int i = 0; i < 127; i++) p[i] = (i % 2 == 0);
        send_entry(8'hA5, p, 1'b0);
        check("overrun_clear_before", int'(overrun), 0);
        send_entry(8'h3C, 128'b1100101, 1'b1);

        // Randomized entries with mixed backpressure.
        for (int n = 0; n < 24; n++) begin
            ready_mode = $urandom_range(0, 2);
            p = {$urandom, $urandom, $urandom, $urandom};
            p = p >> $urandom_range(0, 127);
            if ($urandom_range(0, 7) == 0) p = '0;
            send_entry(8'($urandom), p, 1'b0);
        end

        // Reset in the middle of an entry, after its 5th bit.
        ready_mode = 0;
        x0 = n_xfer;
        push_entry(8'hC3, 128'h1_2345, x0);
        x0 = n_xfer;
        @(posedge clk); #1;
        char_found = 1'b1;
        char_index = 8'hC3;
        char_path  = 128'h1_2345;
        @(posedge clk); #1;
        char_found = 1'b0;
        for (int k = 0; k < 100 && n_xfer < x0 + 5; k++) @(posedge clk);
        check("reset_wait_bits", n_xfer - x0, 5);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_bit_out", int'(bit_out), 0);
        check("midrst_bit_valid", int'(bit_valid), 0);
        check("midrst_write_finish", int'(write_finish), 0);
        check("midrst_overrun", int'(overrun), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send_entry(8'h5A, 128'b1_0110_1001, 1'b0);

        // Finish code.
        ready_mode = 2;
        x0 = n_wf;
`ifdef T05_HEADER_FRAMING_EN
        exp_q.push_back(0);
`endif
        @(posedge clk); #1;
        cb_finished = FIN;
        @(posedge clk); #1;
        cb_finished = 4'd0;
`ifndef T05_HEADER_FRAMING_EN
        @(negedge clk);
        check("fin_next_cycle", int'(header_done), 1);
`endif
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            if (header_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("header_done", int'(ok), 1);
        #1;
        char_found = 1'b1;
        @(posedge clk); #1;
        char_found = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("fin_ignores_bit_valid", int'(bit_valid), 0);
        check("fin_header_done_held", int'(header_done), 1);
        check("fin_no_write_finish", n_wf - x0, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_t05_header_synth
